// File: rtl/core_types_pkg.sv
// Shared core sizing constants for the physical register file write path.
// Also holds the small modular-increment helper used by FIFO and arbiter pointers.
package core_types_pkg;

    localparam int PRF_WR_COUNT             = 8;
    localparam int PRF_BANK_COUNT           = 4;
    localparam int LOG_PRF_BANK_COUNT       = $clog2(PRF_BANK_COUNT);
    localparam int PRF_WR_INPUT_BUFFER_SIZE = 2;
    localparam int PR_COUNT                 = 128;
    localparam int LOG_PR_COUNT             = $clog2(PR_COUNT);

    // Increment with wrap to zero at modulus; modulus need not be a power of two.
    function automatic int wrap_inc(input int val, input int modulus);
        return (val + 1 >= modulus) ? 0 : val + 1;
    endfunction

endpackage

// File: rtl/prf_wr_bank_rr_arb.sv
// Round-robin arbiter for one PRF write bank.
// The priority pointer moves past the winner on every grant and holds otherwise.
module prf_wr_bank_rr_arb
    import core_types_pkg::*;
#(
    parameter int REQ_COUNT = 8,
    parameter int IDX_W     = $clog2(REQ_COUNT)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [REQ_COUNT-1:0] req,
    output logic [REQ_COUNT-1:0] gnt,
    output logic                 gnt_valid,
    output logic [IDX_W-1:0]     gnt_idx
);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt       = '0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            idx = int'(ptr) + k;
            if (idx >= REQ_COUNT) begin
                idx = idx - REQ_COUNT;
            end
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(idx);
            end
        end
        gnt[gnt_idx] = gnt_valid;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr <= '0;
        end else if (gnt_valid) begin
            ptr <= IDX_W'(wrap_inc(int'(gnt_idx), REQ_COUNT));
        end
    end

endmodule

// File: rtl/prf_wr_arbiter.sv
// Collects register writes from all producers into small per-requester FIFOs and
// drains them onto the banked PRF write ports, one round-robin winner per bank.
module prf_wr_arbiter
    import core_types_pkg::*;
#(
    parameter int PRF_WR_COUNT             = core_types_pkg::PRF_WR_COUNT,
    parameter int PRF_BANK_COUNT           = core_types_pkg::PRF_BANK_COUNT,
    parameter int PRF_WR_INPUT_BUFFER_SIZE = core_types_pkg::PRF_WR_INPUT_BUFFER_SIZE,
    parameter int PR_COUNT                 = core_types_pkg::PR_COUNT,
    parameter int LOG_PR_COUNT             = $clog2(PR_COUNT),
    parameter int LOG_PRF_BANK_COUNT       = $clog2(PRF_BANK_COUNT)
) (
    input  logic                                                          CLK,
    input  logic                                                          nRST,
    input  logic [PRF_WR_COUNT-1:0]                                       wr_req_valid_by_req,
    input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]                     wr_req_PR_by_req,
    input  logic [PRF_WR_COUNT-1:0][31:0]                                 wr_req_data_by_req,
    output logic [PRF_WR_COUNT-1:0]                                       wr_req_ready_by_req,
    output logic [PRF_BANK_COUNT-1:0]                                     prf_WEN_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] prf_waddr_by_bank,
    output logic [PRF_BANK_COUNT-1:0][31:0]                               prf_wdata_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]                   prf_wr_PR_by_bank
);

    localparam int DEPTH = PRF_WR_INPUT_BUFFER_SIZE;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (PRF_WR_COUNT > 1) ? $clog2(PRF_WR_COUNT) : 1;

    logic [CNT_W-1:0]        count     [PRF_WR_COUNT];
    logic [PTR_W-1:0]        wr_ptr    [PRF_WR_COUNT];
    logic [PTR_W-1:0]        rd_ptr    [PRF_WR_COUNT];
    logic [LOG_PR_COUNT-1:0] mem_pr    [PRF_WR_COUNT][DEPTH];
    logic [31:0]             mem_data  [PRF_WR_COUNT][DEPTH];

    logic [PRF_WR_COUNT-1:0] enq;
    logic [PRF_WR_COUNT-1:0] deq;
    logic [PRF_WR_COUNT-1:0] head_valid;
    logic [LOG_PR_COUNT-1:0] head_pr   [PRF_WR_COUNT];
    logic [31:0]             head_data [PRF_WR_COUNT];

    logic [PRF_WR_COUNT-1:0] bank_req     [PRF_BANK_COUNT];
    logic [PRF_WR_COUNT-1:0] bank_gnt     [PRF_BANK_COUNT];
    logic [IDX_W-1:0]        bank_gnt_idx [PRF_BANK_COUNT];
    logic [PRF_BANK_COUNT-1:0] bank_gnt_valid;

    // Ready looks only at registered occupancy, so a same-cycle grant never frees a slot early.
    always_comb begin
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            wr_req_ready_by_req[i] = (count[i] < CNT_W'(DEPTH));
            enq[i]                 = wr_req_valid_by_req[i] && wr_req_ready_by_req[i];
            head_valid[i]          = (count[i] != '0);
            head_pr[i]             = mem_pr[i][rd_ptr[i]];
            head_data[i]           = mem_data[i][rd_ptr[i]];
        end
    end

    always_comb begin
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                bank_req[b][i] = head_valid[i] &&
                                 (head_pr[i][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
            end
        end
    end

    // A head targets exactly one bank, so OR-ing the bank grants yields at most one dequeue per FIFO.
    always_comb begin
        deq = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            deq = deq | bank_gnt[b];
        end
    end

    for (genvar g = 0; g < PRF_BANK_COUNT; g++) begin : g_bank
        prf_wr_bank_rr_arb #(
            .REQ_COUNT (PRF_WR_COUNT),
            .IDX_W     (IDX_W)
        ) u_arb (
            .CLK       (CLK),
            .nRST      (nRST),
            .req       (bank_req[g]),
            .gnt       (bank_gnt[g]),
            .gnt_valid (bank_gnt_valid[g]),
            .gnt_idx   (bank_gnt_idx[g])
        );
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (enq[i]) begin
                    wr_ptr[i] <= PTR_W'(wrap_inc(int'(wr_ptr[i]), DEPTH));
                end
                if (deq[i]) begin
                    rd_ptr[i] <= PTR_W'(wrap_inc(int'(rd_ptr[i]), DEPTH));
                end
                case ({enq[i], deq[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Storage needs no reset: an entry is only read once occupancy says it was written.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            if (enq[i]) begin
                mem_pr[i][wr_ptr[i]]   <= wr_req_PR_by_req[i];
                mem_data[i][wr_ptr[i]] <= wr_req_data_by_req[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            prf_WEN_by_bank   <= '0;
            prf_waddr_by_bank <= '0;
            prf_wdata_by_bank <= '0;
            prf_wr_PR_by_bank <= '0;
        end else begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                prf_WEN_by_bank[b] <= bank_gnt_valid[b];
                if (bank_gnt_valid[b]) begin
                    prf_waddr_by_bank[b] <= head_pr[bank_gnt_idx[b]][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
                    prf_wdata_by_bank[b] <= head_data[bank_gnt_idx[b]];
                    prf_wr_PR_by_bank[b] <= head_pr[bank_gnt_idx[b]];
                end
            end
        end
    end

endmodule

// File: tb/tb_prf_wr_arbiter.sv
// Directed bench for the PRF write arbiter: latency, round-robin order, bank parallelism,
// FIFO backpressure with per-requester ordering, and reset while writes are queued.
module tb_prf_wr_arbiter;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [7:0]       valid;
    logic [7:0][6:0]  pr;
    logic [7:0][31:0] data;
    logic [7:0]       ready;
    logic [3:0]       wen;
    logic [3:0][4:0]  waddr;
    logic [3:0][31:0] wdata;
    logic [3:0][6:0]  wpr;

    int passed = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    prf_wr_arbiter dut (
        .CLK                 (CLK),
        .nRST                (nRST),
        .wr_req_valid_by_req (valid),
        .wr_req_PR_by_req    (pr),
        .wr_req_data_by_req  (data),
        .wr_req_ready_by_req (ready),
        .prf_WEN_by_bank     (wen),
        .prf_waddr_by_bank   (waddr),
        .prf_wdata_by_bank   (wdata),
        .prf_wr_PR_by_bank   (wpr)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        valid = '0;
        pr    = '0;
        data  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 1'b0;
        #13;
        total++;
        if (wen !== 4'h0) $display("FAIL reset_wen: got %h expected 0", wen); else passed++;
        total++;
        if (ready !== 8'hFF) $display("FAIL reset_ready: got %h expected ff", ready); else passed++;
        total++;
        if (wpr !== '0 || waddr !== '0 || wdata !== '0)
            $display("FAIL reset_outputs: pr=%h addr=%h data=%h expected all 0", wpr, waddr, wdata);
        else passed++;
        do_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        valid[3] = 1'b1;
        pr[3]    = 7'h25;
        data[3]  = 32'hDEADBEEF;
        tick();
        clear_inputs();
        total++;
        if (wen !== 4'h0) $display("FAIL single_latency: got wen %h expected 0", wen); else passed++;
        tick();
        total++;
        if (wen !== 4'b0010) $display("FAIL single_wen: got %h expected 2", wen); else passed++;
        total++;
        if (waddr[1] !== 5'h09) $display("FAIL single_waddr: got %h expected 09", waddr[1]); else passed++;
        total++;
        if (wpr[1] !== 7'h25) $display("FAIL single_pr: got %h expected 25", wpr[1]); else passed++;
        total++;
        if (wdata[1] !== 32'hDEADBEEF) $display("FAIL single_wdata: got %h expected deadbeef", wdata[1]); else passed++;
        tick();
        total++;
        if (wen !== 4'h0) $display("FAIL single_wen_off: got %h expected 0", wen); else passed++;
        total++;
        if (waddr[1] !== 5'h09 || wpr[1] !== 7'h25)
            $display("FAIL single_hold: got addr %h pr %h expected 09 25", waddr[1], wpr[1]);
        else passed++;
    endtask

    task automatic test_contention();
        logic [6:0] exp_pr [3];
        exp_pr[0] = 7'h04;
        exp_pr[1] = 7'h08;
        exp_pr[2] = 7'h0C;
        do_reset();
        valid[0] = 1'b1; pr[0] = 7'h04; data[0] = 32'd100;
        valid[2] = 1'b1; pr[2] = 7'h08; data[2] = 32'd102;
        valid[5] = 1'b1; pr[5] = 7'h0C; data[5] = 32'd105;
        tick();
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (wen !== 4'b0001 || wpr[0] !== exp_pr[k])
                $display("FAIL contention_grant%0d: got wen %h pr %h expected 1 %h", k, wen, wpr[0], exp_pr[k]);
            else passed++;
        end
        tick();
        total++;
        if (wen !== 4'h0) $display("FAIL contention_idle: got %h expected 0", wen); else passed++;
        // Pointer should now sit at 6: requester 6 must beat requester 0.
        valid[0] = 1'b1; pr[0] = 7'h40; data[0] = 32'd200;
        valid[6] = 1'b1; pr[6] = 7'h18; data[6] = 32'd206;
        tick();
        clear_inputs();
        tick();
        total++;
        if (wpr[0] !== 7'h18) $display("FAIL contention_ptr6_first: got pr %h expected 18", wpr[0]); else passed++;
        tick();
        total++;
        if (wen !== 4'b0001 || wpr[0] !== 7'h40)
            $display("FAIL contention_ptr6_second: got wen %h pr %h expected 1 40", wen, wpr[0]);
        else passed++;
    endtask

    task automatic test_parallel_banks();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            valid[i] = 1'b1;
            pr[i]    = 7'(8'h10 + i);
            data[i]  = 32'h1000 + i;
        end
        tick();
        clear_inputs();
        tick();
        total++;
        if (wen !== 4'hF) $display("FAIL parallel_wen: got %h expected f", wen); else passed++;
        for (int b = 0; b < 4; b++) begin
            total++;
            if (wpr[b] !== 7'(8'h10 + b) || waddr[b] !== 5'h04 || wdata[b] !== 32'h1000 + b)
                $display("FAIL parallel_bank%0d: got pr %h addr %h data %h expected %h 04 %h",
                         b, wpr[b], waddr[b], wdata[b], 8'h10 + b, 32'h1000 + b);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int         seq     [8];
        int         exp_seq [8];
        int         received;
        int         stray;
        int         r;
        int         s;
        logic [7:0] acc;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            seq[i]     = 0;
            exp_seq[i] = 0;
        end
        received = 0;
        stray    = 0;
        for (int cyc = 0; cyc < 200 && received < 32; cyc++) begin
            for (int i = 0; i < 8; i++) begin
                valid[i] = (seq[i] < 4);
                pr[i]    = {3'(i), 2'(seq[i]), 2'b10};
                data[i]  = {16'hA500, 8'(i), 8'(seq[i])};
            end
            acc = valid & ready;
            tick();
            for (int i = 0; i < 8; i++) begin
                if (acc[i]) seq[i]++;
            end
            if (cyc == 0) begin
                total++;
                if (ready[1] !== 1'b1) $display("FAIL bp_ready1_after1: got %b expected 1", ready[1]); else passed++;
            end
            if (cyc == 1) begin
                total++;
                if (ready[1] !== 1'b0) $display("FAIL bp_ready1_after2: got %b expected 0", ready[1]); else passed++;
            end
            if ((wen & 4'b1011) != 4'h0) stray++;
            if (wen[2]) begin
                r = int'(wdata[2][15:8]);
                s = int'(wdata[2][7:0]);
                total++;
                if (r >= 8 || s != exp_seq[r] || wpr[2] !== {3'(r), 2'(s), 2'b10})
                    $display("FAIL bp_order: got req %0d seq %0d pr %h", r, s, wpr[2]);
                else begin
                    passed++;
                    exp_seq[r]++;
                end
                received++;
            end
        end
        clear_inputs();
        total++;
        if (received != 32) $display("FAIL bp_total: got %0d writes expected 32", received); else passed++;
        total++;
        if (stray != 0) $display("FAIL bp_other_banks: got %0d stray enables expected 0", stray); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (exp_seq[i] != 4) $display("FAIL bp_req%0d_count: got %0d expected 4", i, exp_seq[i]); else passed++;
        end
    endtask

    task automatic test_reset_midflight();
        int late;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            valid[i] = 1'b1;
            pr[i]    = 7'(i * 4 + 3);
            data[i]  = 32'h5000 + i;
        end
        tick();
        clear_inputs();
        tick();
        total++;
        if (wen !== 4'b1000) $display("FAIL midflight_pre: got wen %h expected 8", wen); else passed++;
        #2;
        nRST     = 1'b0;
        valid[6] = 1'b1;
        pr[6]    = 7'h07;
        data[6]  = 32'h6666;
        #1;
        total++;
        if (wen !== 4'h0 || wpr !== '0 || waddr !== '0 || wdata !== '0)
            $display("FAIL midflight_async_clear: got wen %h pr %h expected all 0", wen, wpr);
        else passed++;
        tick();
        total++;
        if (ready !== 8'hFF) $display("FAIL midflight_ready: got %h expected ff", ready); else passed++;
        nRST = 1'b1;
        clear_inputs();
        late = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (wen != 4'h0) late++;
        end
        total++;
        if (late != 0) $display("FAIL midflight_no_replay: got %0d enables expected 0", late); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        nRST = 1'b1;
        test_reset();
        test_single_write();
        test_contention();
        test_parallel_banks();
        test_backpressure();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
